// File: rtl/divider_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package divider_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;

  localparam int DIV_WIDTH = 8;
  localparam int CNT_W     = $clog2(DIV_WIDTH);

  // Counter width for a given operand width; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/seq_restoring_divider_subtractor.sv
// Ripple-borrow N-bit subtractor (d = a - b - bin) built from 1-bit full-subtractor cells.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

module nbit_subtractor #(
  parameter int N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic [N-1:0] d,
  output logic         bout
);
  logic [N:0] borrow;

  assign borrow[0] = bin;

  for (genvar i = 0; i < N; i++) begin : g_cell
    full_subtractor u_fs (
      .a    (a[i]),
      .b    (b[i]),
      .bin  (borrow[i]),
      .d    (d[i]),
      .bout (borrow[i+1])
    );
  end

  assign bout = borrow[N];
endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock, start/busy/done handshake.
module seq_restoring_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);

  div_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] den_q, den_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] r_sh;
  logic [WIDTH:0]   sub_d;
  logic             sub_bout;
  logic             restore;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;

  assign r_sh = {r_q[WIDTH-2:0], q_q[WIDTH-1]};

  nbit_subtractor #(.N(WIDTH + 1)) u_sub (
    .a    ({1'b0, r_sh}),
    .b    ({1'b0, den_q}),
    .bin  (1'b0),
    .d    (sub_d),
    .bout (sub_bout)
  );

  // With both MSBs zero the top difference bit equals the final borrow; either marks a negative trial.
  assign restore = sub_bout | sub_d[WIDTH];
  assign r_next  = restore ? r_sh : sub_d[WIDTH-1:0];
  assign q_next  = {q_q[WIDTH-2:0], ~restore};

  always_comb begin
    // NOTE: every signal gets a hold/default value first so no path leaves it unassigned (no latch).
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    den_d   = den_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            state_d = DONE;
            quo_d   = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            done_d  = 1'b1;
          end else begin
            state_d = RUN;
            r_d     = '0;
            q_d     = dividend;
            den_d   = divisor;
            cnt_d   = '0;
            dbz_d   = 1'b0;
            busy_d  = 1'b1;
          end
        end
      end
      RUN: begin
        r_d   = r_next;
        q_d   = q_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          quo_d   = q_next;
          rem_d   = r_next;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      den_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      den_q   <= den_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed and back-to-back self-checking bench for seq_restoring_divider (WIDTH = 8).
module tb_seq_restoring_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int total = 0;
  int bad   = 0;

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           lat;
    int           busy_cycles;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one start for a single edge, then scrambles operands and waits for done.
  // lat counts edges from the accepting edge (inclusive) until done is observed.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat, output int busy_cycles);
    start       = 1'b1;
    dividend    = a;
    divisor     = b;
    lat         = 0;
    busy_cycles = 0;
    while (1) begin
      tick();
      lat++;
      if (lat == 1) begin
        start    = 1'b0;
        dividend = ~a;
        divisor  = b + 8'd3;
      end
      if (busy) busy_cycles++;
      if (done || lat > 40) break;
    end
  endtask

  int lat, bcnt, n, dones, done_at;
  logic [W-1:0] cap_q, cap_r;
  logic [W-1:0] cur_a, cur_b;
  logic         seen_done, seen_busy;

  initial begin
    vecs[0] = '{8'd100, 8'd7,   8'd14,  8'd2,   1'b0, 9, 8};
    vecs[1] = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 9, 8};
    vecs[2] = '{8'd5,   8'd9,   8'd0,   8'd5,   1'b0, 9, 8};
    vecs[3] = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0, 9, 8};
    vecs[4] = '{8'd0,   8'd3,   8'd0,   8'd0,   1'b0, 9, 8};
    vecs[5] = '{8'd128, 8'd16,  8'd8,   8'd0,   1'b0, 9, 8};
    vecs[6] = '{8'd200, 8'd0,   8'hFF,  8'd200, 1'b1, 1, 0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_quotient", quotient, 0);
    check("reset_remainder", remainder, 0);
    check("reset_dbz", div_by_zero, 0);
    reset = 1'b0;
    tick();

    // Table-driven operations, including the divide-by-zero case
    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, lat, bcnt);
      check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d_busy_cycles", i), bcnt, vecs[i].busy_cycles);
      check($sformatf("v%0d_quotient", i), quotient, vecs[i].q);
      check($sformatf("v%0d_remainder", i), remainder, vecs[i].r);
      check($sformatf("v%0d_dbz", i), div_by_zero, vecs[i].dbz);
      tick();
      check($sformatf("v%0d_done_pulse", i), done, 0);
      check($sformatf("v%0d_quotient_hold", i), quotient, vecs[i].q);
      check($sformatf("v%0d_dbz_hold", i), div_by_zero, vecs[i].dbz);
    end

    // Start pulsed mid-RUN must be ignored
    start = 1'b1; dividend = 8'd100; divisor = 8'd7;
    n = 0; dones = 0; done_at = 0; cap_q = '0; cap_r = '0;
    for (int c = 0; c < 30; c++) begin
      tick();
      n++;
      if (n == 1) start = 1'b0;
      if (n == 3) begin start = 1'b1; dividend = 8'd50; divisor = 8'd5; end
      if (n == 4) start = 1'b0;
      if (done) begin dones++; done_at = n; cap_q = quotient; cap_r = remainder; end
    end
    check("ignore_done_count", dones, 1);
    check("ignore_done_at", done_at, 9);
    check("ignore_quotient", cap_q, 14);
    check("ignore_remainder", cap_r, 2);

    // Reset mid-RUN aborts and clears outputs immediately
    start = 1'b1; dividend = 8'd100; divisor = 8'd7;
    tick();
    start = 1'b0;
    repeat (3) tick();
    check("abort_busy_before", busy, 1);
    reset = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_quotient", quotient, 0);
    check("abort_remainder", remainder, 0);
    check("abort_dbz", div_by_zero, 0);
    seen_done = 1'b0;
    repeat (2) begin tick(); if (done) seen_done = 1'b1; end
    reset = 1'b0;
    repeat (12) begin tick(); if (done || busy) seen_done = 1'b1; end
    check("abort_no_done", seen_done, 0);
    do_op(8'd9, 8'd2, lat, bcnt);
    check("post_reset_latency", lat, 9);
    check("post_reset_quotient", quotient, 4);
    check("post_reset_remainder", remainder, 1);
    tick();

    // Back-to-back with start held high
    cur_a = W'($urandom_range(0, 255));
    cur_b = W'($urandom_range(1, 255));
    start = 1'b1; dividend = cur_a; divisor = cur_b;
    seen_busy = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      n = 0;
      while (1) begin
        tick();
        n++;
        if (done || n > 40) break;
      end
      check($sformatf("b2b%0d_interval", i), n, (i == 0) ? 9 : 10);
      check($sformatf("b2b%0d_quotient", i), quotient, cur_a / cur_b);
      check($sformatf("b2b%0d_remainder", i), remainder, cur_a % cur_b);
      if (n > 40) break;
      cur_a = W'($urandom_range(0, 255));
      cur_b = W'($urandom_range(1, 255));
      dividend = cur_a; divisor = cur_b;
    end
    start = 1'b0;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
